// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier issue queue.
package booth_pkg;

    localparam int W_DEF       = 8;
    localparam int PROD_W_DEF  = 2 * W_DEF;
    localparam int TIMEOUT_DEF = 32;

    // Issue sequencer states; one multiplication in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ARM   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Product width for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/booth_issue_queue_op_fifo.sv
// Synchronous operand FIFO. A push while full is dropped and a pop while
// empty is ignored; pointers are log2(DEPTH) bits so they wrap on their own.
module op_fifo
    import booth_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PROD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/booth_issue_queue.sv
// Feeds operand pairs to the Booth multiplier one at a time and returns the
// products in issue order. A stuck multiplier is bounded by TIMEOUT: the pair
// still yields one (zero) result and err latches until reset.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits for ready, and the data held under valid stays
// stable until that transfer.
module booth_issue_queue
    import booth_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_mc,
    input  logic [W-1:0]           in_mp,
    output logic                   mul_start,
    output logic [W-1:0]           mul_mc,
    output logic [W-1:0]           mul_mp,
    input  logic                   mul_busy,
    input  logic [2*W-1:0]         mul_prod,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*W-1:0]         out_prod,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   err
);

    localparam int PW = prod_width(W);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Sequencer state, kept as a named signal so checkers can bind to it.
    state_t         state;
    state_t         state_d;

    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           push;
    logic [PW-1:0]  fifo_dout;
    logic [TW-1:0]  wait_cnt;
    logic           load_ops;
    logic           capture;
    logic           timeout;
    logic           slot_free;

    // in_ready comes straight from the registered occupancy, so a pop in the
    // same cycle does not reopen the input until the following cycle.
    assign push      = in_valid && in_ready;
    assign in_ready  = !fifo_full;
    assign slot_free = !out_valid || out_ready;

    op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_pop),
        .din   ({in_mc, in_mp}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state and per-state strobes. Operands are loaded on entry to ISSUE
    // so mul_mc/mul_mp are already valid while mul_start is high.
    always_comb begin
        state_d   = state;
        mul_start = 1'b0;
        fifo_pop  = 1'b0;
        load_ops  = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !mul_busy && slot_free) begin
                    load_ops = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                fifo_pop  = 1'b1;
                state_d   = ARM;
            end
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!mul_busy) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand, result, timeout and error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_mc    <= '0;
            mul_mp    <= '0;
            out_valid <= 1'b0;
            out_prod  <= '0;
            err       <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (load_ops) {mul_mc, mul_mp} <= fifo_dout;

            if (state == ARM)       wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;

            if (capture) begin
                out_prod  <= mul_prod;
                out_valid <= 1'b1;
            end else if (timeout) begin
                out_prod  <= '0;
                out_valid <= 1'b1;
                err       <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_booth_issue_queue.sv
// Bench for booth_issue_queue: behavioural multiplier stub, cycle model of the
// queue built from the operating rules, directed cases and random traffic.
module tb_booth_issue_queue;

    localparam int DEPTH   = 4;
    localparam int W       = 8;
    localparam int PW      = 16;
    localparam int TIMEOUT = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, mul_start, mul_busy, out_valid, out_ready, err;
    logic [W-1:0]  in_mc, in_mp, mul_mc, mul_mp;
    logic [PW-1:0] mul_prod, out_prod;
    logic [2:0]    pending;

    booth_issue_queue #(.DEPTH(DEPTH), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mc(in_mc), .in_mp(in_mp), .mul_start(mul_start), .mul_mc(mul_mc),
        .mul_mp(mul_mp), .mul_busy(mul_busy), .mul_prod(mul_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .pending(pending), .err(err)
    );

    function automatic logic [PW-1:0] prod16(input logic [W-1:0] a, input logic [W-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return PW'(p);
    endfunction

    // ---------------- multiplier stub (no reset, like the real one) ----------------
    int            busy_len = 9;
    logic          hang = 1'b0, kill = 1'b0, stuck = 1'b0;
    logic          st_busy = 1'b0;
    int            st_cnt = 0;
    logic [PW-1:0] st_prod = '0;

    always @(posedge clk) begin
        if (kill) st_busy <= 1'b0;
        else if (mul_start) begin
            st_busy <= 1'b1;
            st_cnt  <= busy_len;
            st_prod <= prod16(mul_mc, mul_mp);
        end else if (st_busy && !hang) begin
            if (st_cnt <= 1) st_busy <= 1'b0;
            else             st_cnt  <= st_cnt - 1;
        end
    end
    assign mul_busy = st_busy | stuck;
    assign mul_prod = st_busy ? 16'hDEAD : st_prod;

    // ---------------- scoreboard / model state ----------------
    typedef struct packed { logic [W-1:0] mc; logic [W-1:0] mp; } pair_t;
    pair_t         fq[$];
    logic [PW-1:0] got_q[$];
    int            n_vec = 0, n_err = 0;
    logic          model_on = 1'b0;
    int            m_phase = 0, m_wcnt = 0, m_push_cnt = 0;
    logic          m_start = 1'b0, m_ov = 1'b0, m_err = 1'b0;
    logic [PW-1:0] m_prod = '0, m_inflight = '0;
    logic [W-1:0]  m_mc = '0, m_mp = '0;
    int            cyc = 0, start_cnt = 0, start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_phase = 0; m_wcnt = 0; m_start = 1'b0; m_ov = 1'b0; m_err = 1'b0;
        m_prod = '0; m_mc = '0; m_mp = '0;
    endtask

    // One cycle of the queue's rules: m_phase 0 = nothing in flight,
    // 1 = the cycle after the start pulse, 2 = waiting for busy to drop.
    task automatic model_step();
        logic          push_now, elig, cap;
        logic [PW-1:0] cap_val;
        int            n_phase, n_wcnt;
        pair_t         h;
        push_now = in_valid && (fq.size() < DEPTH);
        elig     = (m_phase == 0) && !m_start && (fq.size() > 0) && !mul_busy && (!m_ov || out_ready);
        cap = 1'b0; cap_val = '0; n_phase = m_phase; n_wcnt = m_wcnt;
        if (m_start) begin
            h = fq.pop_front();
            m_inflight = prod16(h.mc, h.mp);
            n_phase = 1;
        end else if (m_phase == 1) begin
            n_phase = 2; n_wcnt = 0;
        end else if (m_phase == 2) begin
            if (!mul_busy) begin
                cap = 1'b1; cap_val = m_inflight; n_phase = 0;
            end else if (m_wcnt + 1 == TIMEOUT) begin
                cap = 1'b1; cap_val = '0; n_phase = 0; m_err = 1'b1;
            end else n_wcnt = m_wcnt + 1;
        end
        if (elig) begin m_mc = fq[0].mc; m_mp = fq[0].mp; end
        if (push_now) begin fq.push_back({in_mc, in_mp}); m_push_cnt++; end
        if (cap) begin m_ov = 1'b1; m_prod = cap_val; end
        else if (m_ov && out_ready) m_ov = 1'b0;
        m_phase = n_phase; m_wcnt = n_wcnt; m_start = elig;
    endtask

    initial forever begin @(posedge clk); cyc++; end

    // Compare process: every cycle, DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("in_ready",  32'(in_ready),  32'(fq.size() < DEPTH));
            check("pending",   32'(pending),   32'(fq.size()));
            check("mul_start", 32'(mul_start), 32'(m_start));
            check("mul_mc",    32'(mul_mc),    32'(m_mc));
            check("mul_mp",    32'(mul_mp),    32'(m_mp));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("out_prod",  32'(out_prod),  32'(m_prod));
            check("err",       32'(err),       32'(m_err));
        end
        if (mul_start === 1'b1) begin start_cnt++; start_cyc = cyc; end
        if (out_valid === 1'b1 && out_ready) got_q.push_back(out_prod);
        if (rst) model_reset(); else model_step();
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_pair(input logic [W-1:0] mc, input logic [W-1:0] mp);
        logic acc;
        in_valid = 1'b1; in_mc = mc; in_mp = mp;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) begin in_valid = 1'b0; return; end
        end
        in_valid = 1'b0;
        n_vec++; n_err++;
        $display("FAIL push_timeout: in_ready never 1 for %0h*%0h", mc, mp);
    endtask

    task automatic wait_ov(input string name, input int exp_lat);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check(name, 32'(cyc - start_cyc), 32'(exp_lat));
                return;
            end
        end
        n_vec++; n_err++;
        $display("FAIL %s: out_valid never rose", name);
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 600; i++) begin
            if (got_q.size() >= n) return;
            tick();
        end
        n_vec++; n_err++;
        $display("FAIL results_timeout: got %0d results expected %0d", got_q.size(), n);
    endtask

    task automatic check_got(input string name, input int idx, input logic [PW-1:0] exp);
        if (idx < got_q.size()) check(name, 32'(got_q[idx]), 32'(exp));
        else check(name, 32'hFFFF_FFFF, 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    logic [PW-1:0] burst_exp [5];
    int s0, p0;

    initial begin
        in_valid = 1'b0; in_mc = '0; in_mp = '0; out_ready = 1'b0;
        repeat (3) tick();
        model_on = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_prod", 32'(out_prod), 32'd0);
        check("rst_mul_mc", 32'({mul_mc, mul_mp}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();

        // Single pair -7 * 3, result held until out_ready.
        got_q.delete(); s0 = start_cnt;
        push_pair(8'hF9, 8'h03);
        wait_ov("single_latency", busy_len + 2);
        repeat (5) tick();
        @(negedge clk);
        check("single_hold_valid", 32'(out_valid), 32'd1);
        check("single_prod", 32'(out_prod), 32'h0000_FFEB);
        check("single_one_start", 32'(start_cnt - s0), 32'd1);
        tick(); out_ready = 1'b1; tick(); out_ready = 1'b0;
        check_got("single_consumed", 0, 16'hFFEB);

        // Burst of five with the multiplier blocked: input stalls after four.
        got_q.delete(); out_ready = 1'b1; stuck = 1'b1;
        push_pair(8'h05, 8'h03);
        push_pair(8'h80, 8'h80);
        push_pair(8'h7F, 8'hFF);
        push_pair(8'h00, 8'hF9);
        @(negedge clk);
        check("burst_full_ready", 32'(in_ready), 32'd0);
        check("burst_full_pending", 32'(pending), 32'd4);
        fork
            push_pair(8'hFF, 8'hFF);
            begin repeat (3) tick(); stuck = 1'b0; end
        join
        wait_results(5);
        burst_exp = '{16'd15, 16'h4000, 16'hFF81, 16'h0000, 16'h0001};
        for (int i = 0; i < 5; i++) check_got("burst_order", i, burst_exp[i]);

        // Output held: no further issue, pending stays at 3.
        got_q.delete(); out_ready = 1'b0;
        push_pair(8'h03, 8'h04);
        wait_ov("hold_latency", busy_len + 2);
        tick(); s0 = start_cnt;
        push_pair(8'h01, 8'h02);
        push_pair(8'hFE, 8'h05);
        push_pair(8'h09, 8'h09);
        repeat (20) tick();
        @(negedge clk);
        check("hold_pending", 32'(pending), 32'd3);
        check("hold_no_issue", 32'(start_cnt - s0), 32'd0);
        check("hold_prod", 32'(out_prod), 32'd12);
        tick(); out_ready = 1'b1;
        wait_results(4);
        check_got("hold_r0", 0, 16'd12);
        check_got("hold_r1", 1, 16'd2);
        check_got("hold_r2", 2, 16'hFFF6);
        check_got("hold_r3", 3, 16'd81);

        // Stuck busy: timeout gives err and a zero result, then recovery.
        got_q.delete(); out_ready = 1'b0; hang = 1'b1;
        push_pair(8'h04, 8'h04);
        wait_ov("timeout_latency", TIMEOUT + 2);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_prod", 32'(out_prod), 32'd0);
        tick();
        push_pair(8'h05, 8'h05);
        out_ready = 1'b1;
        repeat (4) tick();
        hang = 1'b0; kill = 1'b1; tick(); kill = 1'b0;
        wait_results(2);
        check_got("timeout_zero", 0, 16'd0);
        check_got("recover_prod", 1, 16'd25);

        // Reset during WAIT while the multiplier keeps running.
        got_q.delete(); busy_len = 9; s0 = start_cnt;
        push_pair(8'h06, 8'h07);
        for (int i = 0; i < 50 && start_cnt == s0; i++) tick();
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_pending", 32'(pending), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_mul_mc", 32'({mul_mc, mul_mp}), 32'd0);
        check("rst2_still_busy", 32'(mul_busy), 32'd1);
        tick(); s0 = start_cnt;
        push_pair(8'h02, 8'h02);
        wait_results(1);
        repeat (3) tick();
        check_got("rst2_prod", 0, 16'd4);
        check("rst2_discard", 32'(got_q.size()), 32'd1);
        check("rst2_one_start", 32'(start_cnt - s0), 32'd1);

        // Random traffic against the model.
        got_q.delete(); p0 = m_push_cnt;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_mc     = W'($urandom);
            in_mp     = W'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            busy_len  = $urandom_range(1, 10);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (fq.size() == 0 && m_phase == 0 && !m_start && !m_ov) break;
            tick();
        end
        tick();
        check("random_count", 32'(got_q.size()), 32'(m_push_cnt - p0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
